mips_mc_controller: RTL and testbench

MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

---
 rtl/mips_mc_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_mips_mc_controller.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_controller.sv
// mips_mc_controller
// Multi-cycle MIPS control unit. A Moore FSM steps each instruction through
// FETCH/DECODE and an opcode-specific tail, then drives the datapath selects
// and write enables decoded from the current state.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   OpCode, Func        instruction[31:26] and instruction[5:0] from the IR
//   zero_flag           ALU zero, consumed only in BRANCH
//   PCWrite .. PCSrc    datapath control (memory, IR, register file, ALU, PC)
//   illegal_op          registered one-cycle pulse on unsupported opcode/funct
//   inst_count          retired-instruction counter, wraps at 2^32
//
// state    | meaning
// FETCH    | read instruction, PC <= PC + 4
// DECODE   | branch target into ALUOut, dispatch on OpCode
// EXEC_R   | R-type ALU operation, funct checked here
// WB_R     | R-type result to rd
// EXEC_I   | addi/slti ALU operation
// WB_I     | immediate result to rt
// MEM_ADDR | lw/sw effective address
// MEM_RD   | data memory read
// WB_LW    | loaded data to rt
// MEM_WR   | data memory write
// BRANCH   | beq/bne compare, conditional PC load
// JUMP     | j
// JAL      | jal, link register 31 written in the same cycle as the jump
// JR       | jr
module mips_mc_controller #(
  // Value loaded into inst_count by reset; non-zero only to start the
  // counter near its wrap point.
  parameter logic [31:0] COUNT_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  OpCode,
  input  logic [5:0]  Func,
  input  logic        zero_flag,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        Ch_31,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        PCtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOpr,
  output logic [1:0]  PCSrc,
  output logic        illegal_op,
  output logic [31:0] inst_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_WB_LW, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL, S_JR
  } state_t;

  state_t     state;
  logic       retire;
  logic       func_ok;
  logic [2:0] func_alu;

  // R-type funct decode: {supported, ALU operation}
  always_comb begin
    func_ok  = 1'b1;
    func_alu = 3'b000;
    case (Func)
      6'b100000: func_alu = 3'b010;
      6'b100010: func_alu = 3'b110;
      6'b100100: func_alu = 3'b000;
      6'b100101: func_alu = 3'b001;
      6'b101010: func_alu = 3'b111;
      default:   func_ok  = 1'b0;
    endcase
  end

  // Last cycle of every legal instruction, including a not-taken branch.
  assign retire = state inside {S_WB_R, S_WB_I, S_WB_LW, S_MEM_WR,
                                S_BRANCH, S_JUMP, S_JAL, S_JR};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      illegal_op <= 1'b0;
      inst_count <= COUNT_RESET;
    end else begin
      illegal_op <= 1'b0;
      if (retire) inst_count <= inst_count + 32'd1;
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (OpCode)
            OP_RTYPE:       state <= (Func == FN_JR) ? S_JR : S_EXEC_R;
            OP_ADDI,
            OP_SLTI:        state <= S_EXEC_I;
            OP_LW,
            OP_SW:          state <= S_MEM_ADDR;
            OP_BEQ,
            OP_BNE:         state <= S_BRANCH;
            OP_J:           state <= S_JUMP;
            OP_JAL:         state <= S_JAL;
            default: begin
              state      <= S_FETCH;
              illegal_op <= 1'b1;
            end
          endcase
        end
        S_EXEC_R: begin
          if (func_ok) begin
            state <= S_WB_R;
          end else begin
            state      <= S_FETCH;
            illegal_op <= 1'b1;
          end
        end
        S_EXEC_I:   state <= S_WB_I;
        S_MEM_ADDR: state <= (OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   state <= S_WB_LW;
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    Ch_31    = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    PCtoReg  = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOpr   = 3'b000;
    PCSrc    = 2'b00;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
        ALUOpr  = 3'b010;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUOpr  = 3'b010;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOpr  = func_alu;
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOpr  = (OpCode == OP_SLTI) ? 3'b111 : 3'b010;
      end
      S_WB_I:  RegWrite = 1'b1;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOpr  = 3'b010;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_WB_LW: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOpr  = 3'b110;
        PCSrc   = 2'b01;
        // Only Mealy term: the compare result is consumed in this cycle.
        PCWrite = ((OpCode == OP_BEQ) & zero_flag) |
                  ((OpCode == OP_BNE) & ~zero_flag);
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSrc    = 2'b10;
        RegWrite = 1'b1;
        Ch_31    = 1'b1;
        PCtoReg  = 1'b1;
      end
      S_JR: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b11;
      end
      default: ;
    endcase
    // Nothing may be written while reset is held, whatever the state.
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller
// Self-checking bench for mips_mc_controller. Each instruction is run from
// FETCH to the next FETCH while the per-cycle control vector is captured;
// directed tasks check the listed scenarios, and a randomized task checks
// against a per-instruction step table built from the instruction rules.
// A second instance starts its counter at 0xFFFFFFFF to observe the wrap.
module tb_mips_mc_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  OpCode, Func;
  logic        zero_flag;
  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, Ch_31;
  logic        RegWrite, MemtoReg, PCtoReg, ALUSrcA, illegal_op;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [2:0]  ALUOpr;
  logic [31:0] inst_count;

  logic        w_pcw, w_iord, w_mr, w_mw, w_irw, w_rd, w_c31, w_rw, w_m2r;
  logic        w_p2r, w_sa, w_ill;
  logic [1:0]  w_sb, w_ps;
  logic [2:0]  w_op;
  logic [31:0] w_inst_count;

  mips_mc_controller dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Func(Func), .zero_flag(zero_flag),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .Ch_31(Ch_31), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .PCtoReg(PCtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOpr(ALUOpr), .PCSrc(PCSrc),
    .illegal_op(illegal_op), .inst_count(inst_count)
  );

  mips_mc_controller #(.COUNT_RESET(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Func(Func), .zero_flag(zero_flag),
    .PCWrite(w_pcw), .IorD(w_iord), .MemRead(w_mr), .MemWrite(w_mw),
    .IRWrite(w_irw), .RegDst(w_rd), .Ch_31(w_c31), .RegWrite(w_rw),
    .MemtoReg(w_m2r), .PCtoReg(w_p2r), .ALUSrcA(w_sa),
    .ALUSrcB(w_sb), .ALUOpr(w_op), .PCSrc(w_ps),
    .illegal_op(w_ill), .inst_count(w_inst_count)
  );

  always #5 clk = ~clk;

  // Vector field order:
  // PCWrite IorD MemRead MemWrite IRWrite _ RegDst Ch_31 RegWrite MemtoReg
  // PCtoReg _ ALUSrcA _ ALUSrcB _ ALUOpr _ PCSrc
  localparam logic [17:0] V_FETCH = 18'b10101_00000_0_01_010_00;
  localparam logic [17:0] V_DEC   = 18'b00000_00000_0_11_010_00;
  localparam logic [17:0] V_WBR   = 18'b00000_10100_0_00_000_00;
  localparam logic [17:0] V_WBI   = 18'b00000_00100_0_00_000_00;
  localparam logic [17:0] V_MADDR = 18'b00000_00000_1_10_010_00;
  localparam logic [17:0] V_MRD   = 18'b01100_00000_0_00_000_00;
  localparam logic [17:0] V_WBLW  = 18'b00000_00110_0_00_000_00;
  localparam logic [17:0] V_MWR   = 18'b01010_00000_0_00_000_00;
  localparam logic [17:0] V_J     = 18'b10000_00000_0_00_000_10;
  localparam logic [17:0] V_JAL   = 18'b10000_01101_0_00_000_10;
  localparam logic [17:0] V_JR    = 18'b10000_00000_0_00_000_11;
  localparam logic [17:0] ALU_DC  = 18'h3FFE3;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_count;
  logic [17:0] obs_q[$];
  logic [31:0] cnt_q[$];
  logic        ill_q[$];
  logic [31:0] cnt_after;
  logic        ill_after;
  logic [17:0] exp_q[$];
  int          dc_idx;
  logic        exp_legal;

  logic [5:0] legal_ops [10] = '{6'b000000, 6'b001000, 6'b001010, 6'b100011,
                                 6'b101011, 6'b000100, 6'b000101, 6'b000010,
                                 6'b000011, 6'b000000};
  logic [5:0] r_funcs [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b101010, 6'b001000};

  function automatic logic [17:0] obs();
    return {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, Ch_31, RegWrite,
            MemtoReg, PCtoReg, ALUSrcA, ALUSrcB, ALUOpr, PCSrc};
  endfunction

  function automatic logic [17:0] exr_v(input logic [2:0] a);
    return {10'b0, 1'b1, 2'b00, a, 2'b00};
  endfunction

  function automatic logic [17:0] exi_v(input logic [2:0] a);
    return {10'b0, 1'b1, 2'b10, a, 2'b00};
  endfunction

  function automatic logic [17:0] br_v(input logic taken);
    return {taken, 9'b0, 1'b1, 2'b00, 3'b110, 2'b01};
  endfunction

  // Expected per-cycle control vectors for one instruction, FETCH first.
  function automatic void model(input logic [5:0] op, input logic [5:0] f,
                                input logic z);
    logic [2:0] a;
    logic       ok;
    exp_q.delete();
    dc_idx    = -1;
    exp_legal = 1'b1;
    exp_q.push_back(V_FETCH);
    exp_q.push_back(V_DEC);
    case (op)
      6'b000000: begin
        if (f == 6'b001000) begin
          exp_q.push_back(V_JR);
        end else begin
          ok = 1'b1;
          a  = 3'b000;
          case (f)
            6'b100000: a = 3'b010;
            6'b100010: a = 3'b110;
            6'b100100: a = 3'b000;
            6'b100101: a = 3'b001;
            6'b101010: a = 3'b111;
            default:   ok = 1'b0;
          endcase
          exp_q.push_back(exr_v(a));
          if (ok) exp_q.push_back(V_WBR);
          else begin
            exp_legal = 1'b0;
            dc_idx    = 2;
          end
        end
      end
      6'b001000: begin exp_q.push_back(exi_v(3'b010)); exp_q.push_back(V_WBI); end
      6'b001010: begin exp_q.push_back(exi_v(3'b111)); exp_q.push_back(V_WBI); end
      6'b100011: begin
        exp_q.push_back(V_MADDR); exp_q.push_back(V_MRD); exp_q.push_back(V_WBLW);
      end
      6'b101011: begin exp_q.push_back(V_MADDR); exp_q.push_back(V_MWR); end
      6'b000100: exp_q.push_back(br_v(z));
      6'b000101: exp_q.push_back(br_v(~z));
      6'b000010: exp_q.push_back(V_J);
      6'b000011: exp_q.push_back(V_JAL);
      default:   exp_legal = 1'b0;
    endcase
  endfunction

  // Runs one instruction from FETCH until the next FETCH (IRWrite high),
  // capturing control vector, count and illegal_op for every cycle.
  task automatic step_instr(input logic [5:0] op, input logic [5:0] f,
                            input logic z);
    bit done = 1'b0;
    OpCode = op; Func = f; zero_flag = z;
    obs_q.delete(); cnt_q.delete(); ill_q.delete();
    #1;
    obs_q.push_back(obs()); cnt_q.push_back(inst_count); ill_q.push_back(illegal_op);
    repeat (8) begin
      if (!done) begin
        @(negedge clk); #1;
        if (IRWrite) done = 1'b1;
        else begin
          obs_q.push_back(obs()); cnt_q.push_back(inst_count);
          ill_q.push_back(illegal_op);
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL step_timeout op=%b func=%b got no FETCH want FETCH within 8 cycles", op, f);
    end
    cnt_after = inst_count;
    ill_after = illegal_op;
  endtask

  task automatic test_reset();
    rst = 1'b1; OpCode = '0; Func = '0; zero_flag = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({PCWrite, IRWrite, RegWrite, MemWrite, MemRead} !== 5'b0) begin
      errors++;
      $display("FAIL reset_enables got %b want 00000",
               {PCWrite, IRWrite, RegWrite, MemWrite, MemRead});
    end
    checks++;
    if (inst_count !== 32'h0) begin
      errors++; $display("FAIL reset_count got %h want 0", inst_count);
    end
    checks++;
    if (illegal_op !== 1'b0) begin
      errors++; $display("FAIL reset_illegal got %b want 0", illegal_op);
    end
    checks++;
    if (w_inst_count !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL reset_preload got %h want ffffffff", w_inst_count);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (obs() !== V_FETCH) begin
      errors++; $display("FAIL reset_first_fetch got %b want %b", obs(), V_FETCH);
    end
    exp_count = 32'h0;
  endtask

  task automatic test_add();
    step_instr(6'b000000, 6'b100000, 1'(($urandom)));
    checks++;
    if (obs_q.size() != 4) begin
      errors++; $display("FAIL add_len got %0d want 4", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== V_FETCH || obs_q[1] !== V_DEC) begin
        errors++; $display("FAIL add_fetch_decode got %b %b want %b %b",
                           obs_q[0], obs_q[1], V_FETCH, V_DEC);
      end
      checks++;
      if (obs_q[2] !== exr_v(3'b010)) begin
        errors++; $display("FAIL add_exec got %b want %b", obs_q[2], exr_v(3'b010));
      end
      checks++;
      if (obs_q[3] !== V_WBR || cnt_q[3] !== 32'h0) begin
        errors++; $display("FAIL add_wb got %b cnt %h want %b cnt 0",
                           obs_q[3], cnt_q[3], V_WBR);
      end
    end
    exp_count = exp_count + 32'd1;
    checks++;
    if (cnt_after !== exp_count) begin
      errors++; $display("FAIL add_count got %h want %h", cnt_after, exp_count);
    end
  endtask

  task automatic test_lw();
    step_instr(6'b100011, 6'(($urandom)), 1'(($urandom)));
    checks++;
    if (obs_q.size() != 5) begin
      errors++; $display("FAIL lw_len got %0d want 5", obs_q.size());
    end else begin
      checks++;
      if (obs_q[3] !== V_MRD) begin
        errors++; $display("FAIL lw_memrd got %b want %b", obs_q[3], V_MRD);
      end
      checks++;
      if (obs_q[4] !== V_WBLW) begin
        errors++; $display("FAIL lw_wb got %b want %b", obs_q[4], V_WBLW);
      end
    end
    exp_count = exp_count + 32'd1;
    checks++;
    if (cnt_after !== exp_count) begin
      errors++; $display("FAIL lw_count got %h want %h", cnt_after, exp_count);
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 4; i++) begin
      logic [5:0] op;
      logic       z, taken;
      op    = (i < 2) ? 6'b000100 : 6'b000101;
      z     = (i % 2) == 1;
      taken = (op == 6'b000100) ? z : ~z;
      step_instr(op, 6'(($urandom)), z);
      checks++;
      if (obs_q.size() != 3 || obs_q[2] !== br_v(taken)) begin
        errors++;
        $display("FAIL branch op=%b z=%b got len %0d vec %b want len 3 vec %b",
                 op, z, obs_q.size(), obs_q[obs_q.size()-1], br_v(taken));
      end
      exp_count = exp_count + 32'd1;
      checks++;
      if (cnt_after !== exp_count) begin
        errors++; $display("FAIL branch_count op=%b z=%b got %h want %h",
                           op, z, cnt_after, exp_count);
      end
    end
  endtask

  task automatic test_jal();
    step_instr(6'b000011, 6'(($urandom)), 1'(($urandom)));
    checks++;
    if (obs_q.size() != 3 || obs_q[2] !== V_JAL) begin
      errors++; $display("FAIL jal got len %0d vec %b want len 3 vec %b",
                         obs_q.size(), obs_q[obs_q.size()-1], V_JAL);
    end
    exp_count = exp_count + 32'd1;
    checks++;
    if (cnt_after !== exp_count) begin
      errors++; $display("FAIL jal_count got %h want %h", cnt_after, exp_count);
    end
  endtask

  task automatic test_illegal();
    logic any_wr;
    step_instr(6'b111111, 6'(($urandom)), 1'(($urandom)));
    any_wr = 1'b0;
    foreach (obs_q[i]) any_wr = any_wr | obs_q[i][10] | obs_q[i][14];
    checks++;
    if (obs_q.size() != 2 || any_wr !== 1'b0) begin
      errors++; $display("FAIL illegal_op_path got len %0d writes %b want len 2 writes 0",
                         obs_q.size(), any_wr);
    end
    checks++;
    if (ill_after !== 1'b1 || cnt_after !== exp_count) begin
      errors++; $display("FAIL illegal_op_pulse got ill %b cnt %h want ill 1 cnt %h",
                         ill_after, cnt_after, exp_count);
    end
    step_instr(6'b000010, 6'(($urandom)), 1'(($urandom)));
    checks++;
    if (ill_q[0] !== 1'b1 || ill_q[1] !== 1'b0) begin
      errors++; $display("FAIL illegal_pulse_width got %b%b want 10", ill_q[0], ill_q[1]);
    end
    exp_count = exp_count + 32'd1;
    step_instr(6'b000000, 6'b111111, 1'(($urandom)));
    any_wr = 1'b0;
    foreach (obs_q[i]) any_wr = any_wr | obs_q[i][10] | obs_q[i][14];
    checks++;
    if (obs_q.size() != 3 || any_wr !== 1'b0 || ill_after !== 1'b1 ||
        cnt_after !== exp_count) begin
      errors++;
      $display("FAIL illegal_func got len %0d wr %b ill %b cnt %h want len 3 wr 0 ill 1 cnt %h",
               obs_q.size(), any_wr, ill_after, cnt_after, exp_count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op, f;
      logic       z;
      logic [17:0] m;
      op = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 9)]
                                      : 6'($urandom);
      f  = ($urandom_range(0, 3) < 3) ? r_funcs[$urandom_range(0, 5)]
                                      : 6'($urandom);
      z  = 1'($urandom);
      model(op, f, z);
      step_instr(op, f, z);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand_len op=%b func=%b got %0d want %0d",
                           op, f, obs_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          m = (i == dc_idx) ? ALU_DC : '1;
          checks++;
          if ((obs_q[i] & m) !== (exp_q[i] & m)) begin
            errors++; $display("FAIL rand_vec op=%b func=%b z=%b cyc %0d got %b want %b",
                               op, f, z, i, obs_q[i], exp_q[i]);
          end
        end
      end
      if (exp_legal) exp_count = exp_count + 32'd1;
      checks++;
      if (cnt_after !== exp_count || ill_after !== ~exp_legal) begin
        errors++; $display("FAIL rand_status op=%b func=%b got cnt %h ill %b want cnt %h ill %b",
                           op, f, cnt_after, ill_after, exp_count, ~exp_legal);
      end
    end
  endtask

  task automatic test_reset_mid();
    OpCode = 6'b101011; Func = 6'($urandom); zero_flag = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (obs() !== V_MWR) begin
      errors++; $display("FAIL rst_mid_memwr got %b want %b", obs(), V_MWR);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({PCWrite, IRWrite, RegWrite, MemWrite, MemRead} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_enables got %b want 00000",
                         {PCWrite, IRWrite, RegWrite, MemWrite, MemRead});
    end
    @(negedge clk); #1;
    checks++;
    if (inst_count !== 32'h0 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL rst_mid_count got %h ill %b want 0 ill 0",
                         inst_count, illegal_op);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (obs() !== V_FETCH) begin
      errors++; $display("FAIL rst_mid_fetch got %b want %b", obs(), V_FETCH);
    end
    exp_count = 32'h0;
  endtask

  task automatic test_wrap();
    checks++;
    if (w_inst_count !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_preload got %h want ffffffff", w_inst_count);
    end
    step_instr(6'b000010, 6'(($urandom)), 1'(($urandom)));
    exp_count = exp_count + 32'd1;
    checks++;
    if (w_inst_count !== 32'h0 || cnt_after !== exp_count) begin
      errors++; $display("FAIL wrap got %h main %h want 0 main %h",
                         w_inst_count, cnt_after, exp_count);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_branch();
    test_jal();
    test_illegal();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
